e203_exu_longp_cplt: RTL and testbench

In-order completion collector for long-pipe instructions (LSU loads, MULDIV). Allocates an instruction tag (itag) at dispatch, captures out-of-order completions from the two long-pipe sources into a tag-indexed table, and releases results strictly in dispatch order on the `longp_wbck_i_*` port of `e203_exu_wbck`. Sits directly upstream of `e203_exu_wbck`.

---
 rtl/e203_longp_pkg.sv | 26 ++
 rtl/e203_exu_longp_ptr.sv | 41 ++++
 rtl/e203_exu_longp_cplt.sv | 147 ++++++++++++++
 tb/tb_e203_exu_longp_cplt.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_longp_pkg.sv
// Shared widths and the completion-table entry layout for the long-pipe
// completion collector.
package e203_longp_pkg;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;
  localparam int FLAGS_W = 5;

  // One slot of the in-order completion table.
  typedef struct packed {
    logic               alloc;  // slot holds a dispatched, unretired instruction
    logic               done;   // result has been captured
    logic [RFIDX_W-1:0] rdidx;  // destination register index
    logic               rdfpu;  // destination is the FPU register file
    logic [XLEN-1:0]    wdat;   // result data
    logic [FLAGS_W-1:0] flags;  // exception/FP flags (LSU always writes zero)
  } longp_entry_t;

  // Fully cleared slot, used at reset.
  function automatic longp_entry_t longp_entry_clear();
    longp_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/e203_exu_longp_ptr.sv
// Circular table pointer with an extra wrap bit above the index bits, so
// that equal indices can be told apart as "empty" or "full".
module e203_exu_longp_ptr
  import e203_longp_pkg::*;
#(
  parameter int ITAG_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  output logic [ITAG_W:0] ptr_o
);

  localparam logic [ITAG_W:0] PTR_ONE  = {{ITAG_W{1'b0}}, 1'b1};
  localparam logic [ITAG_W:0] PTR_ZERO = {(ITAG_W+1){1'b0}};

  logic [ITAG_W:0] ptr_q;
  logic [ITAG_W:0] ptr_d;

  // Advance by one when enabled; the MSB toggles every time the index wraps.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + PTR_ONE;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_ZERO;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/e203_exu_longp_cplt.sv
// In-order completion collector for long-pipe instructions (LSU, MULDIV).
// Dispatch allocates a tag, the two sources complete out of order into a
// tag-indexed table, and results leave strictly in dispatch order.
module e203_exu_longp_cplt #(
  parameter int OITF_DEPTH = 2,
  parameter int ITAG_W     = 1,
  parameter int XLEN       = e203_longp_pkg::XLEN,
  parameter int RFIDX_W    = e203_longp_pkg::RFIDX_W
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               disp_valid,
  output logic               disp_ready,
  input  logic [RFIDX_W-1:0] disp_rdidx,
  input  logic               disp_rdfpu,
  output logic [ITAG_W-1:0]  disp_itag,

  input  logic               lsu_cplt_valid,
  output logic               lsu_cplt_ready,
  input  logic [ITAG_W-1:0]  lsu_cplt_itag,
  input  logic [XLEN-1:0]    lsu_cplt_wdat,

  input  logic               mdv_cplt_valid,
  output logic               mdv_cplt_ready,
  input  logic [ITAG_W-1:0]  mdv_cplt_itag,
  input  logic [XLEN-1:0]    mdv_cplt_wdat,
  input  logic [4:0]         mdv_cplt_flags,

  output logic               longp_wbck_o_valid,
  input  logic               longp_wbck_o_ready,
  output logic [XLEN-1:0]    longp_wbck_o_wdat,
  output logic [4:0]         longp_wbck_o_flags,
  output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
  output logic               longp_wbck_o_rdfpu,

  output logic               oitf_empty
);

  import e203_longp_pkg::*;

  logic [ITAG_W:0]   wptr_s;
  logic [ITAG_W:0]   rptr_s;
  logic [ITAG_W-1:0] widx_s;
  logic [ITAG_W-1:0] ridx_s;
  logic              full_s;
  logic              empty_s;
  logic              disp_fire_s;
  logic              wbck_fire_s;
  logic              lsu_hit_s;
  logic              mdv_collide_s;
  logic              mdv_hit_s;
  longp_entry_t      head_s;

  longp_entry_t      entry_q [OITF_DEPTH];
  longp_entry_t      entry_d [OITF_DEPTH];

  // Write pointer: advances on every accepted dispatch.
  e203_exu_longp_ptr #(.ITAG_W(ITAG_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (disp_fire_s),
    .ptr_o (wptr_s)
  );

  // Read pointer: advances on every retired result.
  e203_exu_longp_ptr #(.ITAG_W(ITAG_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wbck_fire_s),
    .ptr_o (rptr_s)
  );

  assign widx_s  = wptr_s[ITAG_W-1:0];
  assign ridx_s  = rptr_s[ITAG_W-1:0];
  assign empty_s = (wptr_s == rptr_s);
  assign full_s  = (widx_s == ridx_s) && (wptr_s[ITAG_W] != rptr_s[ITAG_W]);

  assign disp_ready  = ~full_s;
  assign disp_itag   = widx_s;
  assign oitf_empty  = empty_s;
  assign disp_fire_s = disp_valid & ~full_s;

  // LSU always wins a same-tag collision, so it never needs to stall.
  assign lsu_cplt_ready = 1'b1;
  assign mdv_collide_s  = lsu_cplt_valid & mdv_cplt_valid & (lsu_cplt_itag == mdv_cplt_itag);
  assign mdv_cplt_ready = ~mdv_collide_s;

  // A completion only lands on a slot that is allocated and still pending;
  // anything else is accepted and silently dropped.
  assign lsu_hit_s = lsu_cplt_valid
                   & entry_q[lsu_cplt_itag].alloc & ~entry_q[lsu_cplt_itag].done;
  assign mdv_hit_s = mdv_cplt_valid & ~mdv_collide_s
                   & entry_q[mdv_cplt_itag].alloc & ~entry_q[mdv_cplt_itag].done;

  // Head slot drives the writeback port straight from table registers, so a
  // captured result shows up one cycle after its completion and stays put.
  assign head_s             = entry_q[ridx_s];
  assign longp_wbck_o_valid = head_s.alloc & head_s.done;
  assign longp_wbck_o_wdat  = head_s.wdat;
  assign longp_wbck_o_flags = head_s.flags;
  assign longp_wbck_o_rdidx = head_s.rdidx;
  assign longp_wbck_o_rdfpu = head_s.rdfpu;
  assign wbck_fire_s        = longp_wbck_o_valid & longp_wbck_o_ready;

  // Per-slot next state. The cases are mutually exclusive: a retiring slot is
  // already done (completions drop), a dispatch target is unallocated
  // (completions drop), and a colliding MULDIV completion is refused.
  always_comb begin
    for (int i = 0; i < OITF_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (wbck_fire_s && (ridx_s == ITAG_W'(i))) begin
        entry_d[i].alloc = 1'b0;
        entry_d[i].done  = 1'b0;
      end else if (disp_fire_s && (widx_s == ITAG_W'(i))) begin
        entry_d[i].alloc = 1'b1;
        entry_d[i].done  = 1'b0;
        entry_d[i].rdidx = disp_rdidx;
        entry_d[i].rdfpu = disp_rdfpu;
      end else if (lsu_hit_s && (lsu_cplt_itag == ITAG_W'(i))) begin
        entry_d[i].done  = 1'b1;
        entry_d[i].wdat  = lsu_cplt_wdat;
        entry_d[i].flags = 5'b00000;
      end else if (mdv_hit_s && (mdv_cplt_itag == ITAG_W'(i))) begin
        entry_d[i].done  = 1'b1;
        entry_d[i].wdat  = mdv_cplt_wdat;
        entry_d[i].flags = mdv_cplt_flags;
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
  end

  // Completion table storage, fully cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        entry_q[i] <= longp_entry_clear();
      end
    end else begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_longp_cplt.sv
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized run checked every cycle against an in-order queue model.
module tb_e203_exu_longp_cplt;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_rdidx;
  logic        disp_rdfpu;
  logic [0:0]  disp_itag;
  logic        lsu_v;
  logic        lsu_ready;
  logic [0:0]  lsu_itag;
  logic [31:0] lsu_wdat;
  logic        mdv_v;
  logic        mdv_ready;
  logic [0:0]  mdv_itag;
  logic [31:0] mdv_wdat;
  logic [4:0]  mdv_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_wdat;
  logic [4:0]  wb_flags;
  logic [4:0]  wb_rdidx;
  logic        wb_rdfpu;
  logic        empty;

  int n_vec = 0;
  int n_err = 0;

  e203_exu_longp_cplt #(.OITF_DEPTH(2), .ITAG_W(1), .XLEN(32), .RFIDX_W(5)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .disp_valid         (disp_valid),
    .disp_ready         (disp_ready),
    .disp_rdidx         (disp_rdidx),
    .disp_rdfpu         (disp_rdfpu),
    .disp_itag          (disp_itag),
    .lsu_cplt_valid     (lsu_v),
    .lsu_cplt_ready     (lsu_ready),
    .lsu_cplt_itag      (lsu_itag),
    .lsu_cplt_wdat      (lsu_wdat),
    .mdv_cplt_valid     (mdv_v),
    .mdv_cplt_ready     (mdv_ready),
    .mdv_cplt_itag      (mdv_itag),
    .mdv_cplt_wdat      (mdv_wdat),
    .mdv_cplt_flags     (mdv_flags),
    .longp_wbck_o_valid (wb_valid),
    .longp_wbck_o_ready (wb_ready),
    .longp_wbck_o_wdat  (wb_wdat),
    .longp_wbck_o_flags (wb_flags),
    .longp_wbck_o_rdidx (wb_rdidx),
    .longp_wbck_o_rdfpu (wb_rdfpu),
    .oitf_empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: ordered list of in-flight instrs ----
  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic        fpu;
    logic        done;
    logic [31:0] wdat;
    logic [4:0]  flags;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_next = 0;
  bit     m_disp;
  bit     m_ret;
  bit     m_mdv_ok;
  m_ent_t m_new;
  bit     e_valid;

  // Model update at each rising edge from the inputs presented this cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_next = 0;
    end else begin
      m_disp   = disp_valid && (mq.size() < DEPTH);
      m_ret    = (mq.size() > 0) && mq[0].done && wb_ready;
      m_mdv_ok = mdv_v && !(lsu_v && (lsu_itag == mdv_itag));
      for (int k = 0; k < mq.size(); k++) begin
        if (lsu_v && (mq[k].tag == int'(lsu_itag)) && !mq[k].done) begin
          mq[k].done  = 1'b1;
          mq[k].wdat  = lsu_wdat;
          mq[k].flags = 5'd0;
        end else if (m_mdv_ok && (mq[k].tag == int'(mdv_itag)) && !mq[k].done) begin
          mq[k].done  = 1'b1;
          mq[k].wdat  = mdv_wdat;
          mq[k].flags = mdv_flags;
        end
      end
      if (m_ret) void'(mq.pop_front());
      if (m_disp) begin
        m_new.tag   = m_next;
        m_new.rd    = disp_rdidx;
        m_new.fpu   = disp_rdfpu;
        m_new.done  = 1'b0;
        m_new.wdat  = 32'd0;
        m_new.flags = 5'd0;
        mq.push_back(m_new);
        m_next = (m_next + 1) % DEPTH;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_itag", 64'(disp_itag), 64'd0);
      chk("rst_dready", 64'(disp_ready), 64'd1);
      chk("rst_wdat", 64'(wb_wdat), 64'd0);
    end else begin
      e_valid = (mq.size() > 0) && mq[0].done;
      chk("m_dready", 64'(disp_ready), 64'(mq.size() < DEPTH));
      chk("m_itag", 64'(disp_itag), 64'(m_next));
      chk("m_empty", 64'(empty), 64'(mq.size() == 0));
      chk("m_lready", 64'(lsu_ready), 64'd1);
      chk("m_mready", 64'(mdv_ready), 64'(!(lsu_v && mdv_v && (lsu_itag == mdv_itag))));
      chk("m_valid", 64'(wb_valid), 64'(e_valid));
      if (e_valid) begin
        chk("m_wdat", 64'(wb_wdat), 64'(mq[0].wdat));
        chk("m_flags", 64'(wb_flags), 64'(mq[0].flags));
        chk("m_rdidx", 64'(wb_rdidx), 64'(mq[0].rd));
        chk("m_rdfpu", 64'(wb_rdfpu), 64'(mq[0].fpu));
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic idle();
    disp_valid = 1'b0; disp_rdidx = 5'd0; disp_rdfpu = 1'b0;
    lsu_v = 1'b0; lsu_itag = 1'b0; lsu_wdat = 32'd0;
    mdv_v = 1'b0; mdv_itag = 1'b0; mdv_wdat = 32'd0; mdv_flags = 5'd0;
    wb_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic disp(input logic [4:0] rd);
    disp_valid = 1'b1; disp_rdidx = rd;
    cyc();
    disp_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("init_dready", 64'(disp_ready), 64'd1);
    chk("init_itag", 64'(disp_itag), 64'd0);
    chk("init_empty", 64'(empty), 64'd1);
    chk("init_valid", 64'(wb_valid), 64'd0);
    chk("init_wdat", 64'(wb_wdat), 64'd0);
    chk("init_rdidx", 64'(wb_rdidx), 64'd0);
    chk("init_flags", 64'(wb_flags), 64'd0);
    cyc();
    rst_n = 1'b1;

    // Single LSU load, one-cycle completion latency, retire.
    do_reset();
    settle(); chk("t1_itag0", 64'(disp_itag), 64'd0);
    disp(5'd5);
    lsu_v = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'hDEADBEEF;
    settle(); chk("t1_no_bypass", 64'(wb_valid), 64'd0);
    cyc(); lsu_v = 1'b0;
    settle();
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_wdat", 64'(wb_wdat), 64'hDEADBEEF);
    chk("t1_rdidx", 64'(wb_rdidx), 64'd5);
    chk("t1_flags", 64'(wb_flags), 64'd0);
    wb_ready = 1'b1; cyc(); wb_ready = 1'b0;
    settle(); chk("t1_empty", 64'(empty), 64'd1);

    // Out-of-order completion, in-order release.
    do_reset();
    disp(5'd1); disp(5'd2);
    mdv_v = 1'b1; mdv_itag = 1'b1; mdv_wdat = 32'h22; mdv_flags = 5'h3;
    cyc(); mdv_v = 1'b0;
    lsu_v = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'h11;
    settle(); chk("t2_hold_order", 64'(wb_valid), 64'd0);
    cyc(); lsu_v = 1'b0;
    settle();
    chk("t2_first_rd", 64'(wb_rdidx), 64'd1);
    chk("t2_first_wdat", 64'(wb_wdat), 64'h11);
    wb_ready = 1'b1; cyc();
    settle();
    chk("t2_second_valid", 64'(wb_valid), 64'd1);
    chk("t2_second_rd", 64'(wb_rdidx), 64'd2);
    chk("t2_second_wdat", 64'(wb_wdat), 64'h22);
    chk("t2_second_flags", 64'(wb_flags), 64'h3);
    cyc(); wb_ready = 1'b0;
    settle(); chk("t2_empty", 64'(empty), 64'd1);

    // Full table: dispatch refused while retiring, accepted next cycle.
    do_reset();
    disp(5'd3); disp(5'd4);
    lsu_v = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'h33;
    settle(); chk("t3_full", 64'(disp_ready), 64'd0);
    cyc(); lsu_v = 1'b0;
    disp_valid = 1'b1; disp_rdidx = 5'd6; wb_ready = 1'b1;
    settle();
    chk("t3_refused", 64'(disp_ready), 64'd0);
    chk("t3_head_valid", 64'(wb_valid), 64'd1);
    cyc(); wb_ready = 1'b0;
    settle();
    chk("t3_ready_again", 64'(disp_ready), 64'd1);
    chk("t3_wrap_itag", 64'(disp_itag), 64'd0);
    cyc(); disp_valid = 1'b0;
    settle(); chk("t3_full_again", 64'(disp_ready), 64'd0);

    // Same-tag collision (LSU wins) and different-tag dual completion.
    do_reset();
    disp(5'd7); disp(5'd8);
    lsu_v = 1'b1; lsu_itag = 1'b1; lsu_wdat = 32'hAAAA0001;
    mdv_v = 1'b1; mdv_itag = 1'b1; mdv_wdat = 32'hBBBB0002; mdv_flags = 5'h1F;
    settle();
    chk("t4_mdv_blocked", 64'(mdv_ready), 64'd0);
    chk("t4_lsu_ready", 64'(lsu_ready), 64'd1);
    cyc(); lsu_v = 1'b0;
    mdv_itag = 1'b0; mdv_wdat = 32'h55550003; mdv_flags = 5'h2;
    settle(); chk("t4_mdv_ok", 64'(mdv_ready), 64'd1);
    cyc(); mdv_v = 1'b0; wb_ready = 1'b1;
    settle();
    chk("t4_h0_wdat", 64'(wb_wdat), 64'h55550003);
    chk("t4_h0_flags", 64'(wb_flags), 64'h2);
    cyc(); settle();
    chk("t4_h1_rd", 64'(wb_rdidx), 64'd8);
    chk("t4_h1_wdat", 64'(wb_wdat), 64'hAAAA0001);
    cyc(); wb_ready = 1'b0;
    disp(5'd10); disp(5'd11);
    lsu_v = 1'b1; lsu_itag = 1'b1; lsu_wdat = 32'hC0DE0001;
    mdv_v = 1'b1; mdv_itag = 1'b0; mdv_wdat = 32'hF00D0002; mdv_flags = 5'h4;
    settle(); chk("t4_both_ready", 64'(mdv_ready), 64'd1);
    cyc(); lsu_v = 1'b0; mdv_v = 1'b0; wb_ready = 1'b1;
    settle();
    chk("t4_d0_rd", 64'(wb_rdidx), 64'd10);
    chk("t4_d0_wdat", 64'(wb_wdat), 64'hF00D0002);
    cyc(); settle();
    chk("t4_d1_wdat", 64'(wb_wdat), 64'hC0DE0001);
    chk("t4_d1_flags", 64'(wb_flags), 64'h0);
    cyc(); wb_ready = 1'b0;

    // Backpressure hold, then asynchronous reset in the middle of it.
    do_reset();
    disp(5'd9);
    lsu_v = 1'b1; lsu_itag = 1'b0; lsu_wdat = 32'h12345678;
    cyc(); lsu_v = 1'b0;
    for (int h = 0; h < 5; h++) begin
      settle();
      chk("t5_hold_valid", 64'(wb_valid), 64'd1);
      chk("t5_hold_wdat", 64'(wb_wdat), 64'h12345678);
      cyc();
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(wb_valid), 64'd0);
    chk("t5_rst_empty", 64'(empty), 64'd1);
    chk("t5_rst_itag", 64'(disp_itag), 64'd0);
    cyc();
    rst_n = 1'b1;

    // Randomized traffic against the model, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 599) != 0);
      disp_valid = ($urandom_range(0, 1) == 1);
      disp_rdidx = 5'($urandom_range(0, 31));
      disp_rdfpu = ($urandom_range(0, 3) == 0);
      lsu_v      = ($urandom_range(0, 4) < 2);
      lsu_itag   = 1'($urandom_range(0, 1));
      lsu_wdat   = $urandom;
      mdv_v      = ($urandom_range(0, 4) < 2);
      mdv_itag   = 1'($urandom_range(0, 1));
      mdv_wdat   = $urandom;
      mdv_flags  = 5'($urandom_range(0, 31));
      wb_ready   = ($urandom_range(0, 4) < 3);
      cyc();
    end
    idle();
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
